csb_arbiter: RTL and testbench



---
 rtl/csb_arbiter.sv | 79 +++++++
 tb/tb_csb_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/csb_arbiter.sv
// csb_arbiter: round-robin two-master arbiter onto one CSB slave port with in-order response routing.
module csb_arbiter #(
  parameter int OUTSTANDING = 4,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [1:0]                        m_valid,
  output logic [1:0]                        m_ready,
  input  logic [1:0][ADDR_WIDTH-1:0]        m_addr,
  input  logic [1:0][31:0]                  m_wdat,
  input  logic [1:0]                        m_write,
  input  logic [1:0]                        m_nposted,
  output logic [1:0]                        m_rvalid,
  output logic [1:0][31:0]                  m_rdata,
  output logic [1:0]                        m_wr_complete,
  output logic                              s_valid,
  input  logic                              s_ready,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [31:0]                       s_wdat,
  output logic                              s_write,
  output logic                              s_nposted,
  input  logic                              s_rvalid,
  input  logic [31:0]                       s_rdata,
  input  logic                              s_wr_complete,
  output logic [$clog2(OUTSTANDING+1)-1:0]  outstanding,
  output logic                              resp_err
);
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int PW = OUTSTANDING > 1 ? $clog2(OUTSTANDING) : 1;
  logic lock, grant_id, rr_prio, grant, sel, accept, push, pop, resp, head;
  logic [OUTSTANDING-1:0] fifo;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction
  // A full owner FIFO blocks every new selection, posted writes included.
  assign sel       = rst_n & ~lock & (count != CW'(OUTSTANDING)) & |m_valid;
  assign grant     = lock ? grant_id : (&m_valid ? rr_prio : m_valid[1]);
  assign s_valid   = sel | lock;
  assign accept    = s_valid & s_ready;
  assign m_ready   = {accept & grant, accept & ~grant};
  assign s_addr    = m_addr[grant];
  assign s_wdat    = m_wdat[grant];
  assign s_write   = m_write[grant];
  assign s_nposted = m_nposted[grant];
  assign push      = accept & (~s_write | s_nposted);
  assign resp      = rst_n & (s_rvalid | s_wr_complete);
  assign pop       = resp & (count != '0);
  assign head      = fifo[rd_ptr];
  assign m_rvalid      = {2{pop & s_rvalid}} & {head, ~head};
  assign m_wr_complete = {2{pop & s_wr_complete}} & {head, ~head};
  assign m_rdata     = {s_rdata, s_rdata};
  assign outstanding = count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock     <= 1'b0;
      grant_id <= 1'b0;
      rr_prio  <= 1'b0;
      fifo     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      resp_err <= 1'b0;
    end else begin
      lock <= s_valid & ~s_ready;
      if (s_valid & ~s_ready) grant_id <= grant;
      if (accept) rr_prio <= ~grant;
      if (push) begin
        fifo[wr_ptr] <= grant;
        wr_ptr       <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
      if (resp & (count == '0)) resp_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_csb_arbiter.sv
// tb_csb_arbiter: directed literal checks plus randomized traffic compared against a queue-based model.
module tb_csb_arbiter;
  localparam int OUT = 4;
  localparam int AW  = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] m_valid, m_ready, m_write, m_nposted, m_rvalid, m_wr_complete;
  logic [1:0][AW-1:0] m_addr;
  logic [1:0][31:0] m_wdat, m_rdata;
  logic s_valid, s_ready, s_write, s_nposted, s_rvalid, s_wr_complete, resp_err;
  logic [AW-1:0] s_addr;
  logic [31:0] s_wdat, s_rdata;
  logic [$clog2(OUT+1)-1:0] outstanding;

  csb_arbiter #(.OUTSTANDING(OUT), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
    .m_wdat(m_wdat), .m_write(m_write), .m_nposted(m_nposted), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .m_wr_complete(m_wr_complete), .s_valid(s_valid), .s_ready(s_ready),
    .s_addr(s_addr), .s_wdat(s_wdat), .s_write(s_write), .s_nposted(s_nposted),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_wr_complete(s_wr_complete),
    .outstanding(outstanding), .resp_err(resp_err));

  int checks = 0;
  int errors = 0;
  int q[$];
  int held = -1;
  int prio = 0;
  bit err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which master the slave port is serving this cycle, or -1.
  function automatic int pick();
    if (!rst_n) return -1;
    if (held >= 0) return held;
    if (q.size() >= OUT || m_valid == 2'b00) return -1;
    if (m_valid == 2'b11) return prio;
    return m_valid[1] ? 1 : 0;
  endfunction

  task automatic compare();
    int g;
    logic [1:0] er, erv, ewc;
    if (!rst_n) begin
      q.delete();
      held = -1;
      prio = 0;
      err = 0;
    end
    g = pick();
    er = (g >= 0 && s_ready) ? 2'(1 << g) : 2'b00;
    erv = 2'b00;
    ewc = 2'b00;
    if (rst_n && q.size() > 0) begin
      if (s_rvalid) erv = 2'(1 << q[0]);
      if (s_wr_complete) ewc = 2'(1 << q[0]);
    end
    chk("m_ready", m_ready, er);
    chk("s_valid", s_valid, g >= 0);
    if (g >= 0) begin
      chk("s_addr", s_addr, m_addr[g]);
      chk("s_wdat", s_wdat, m_wdat[g]);
      chk("s_write", s_write, m_write[g]);
      chk("s_nposted", s_nposted, m_nposted[g]);
    end
    chk("m_rvalid", m_rvalid, erv);
    chk("m_wr_complete", m_wr_complete, ewc);
    chk("m_rdata0", m_rdata[0], s_rdata);
    chk("m_rdata1", m_rdata[1], s_rdata);
    chk("outstanding", outstanding, q.size());
    chk("resp_err", resp_err, err);
  endtask

  task automatic update();
    int g;
    g = pick();
    if (s_rvalid || s_wr_complete) begin
      if (q.size() == 0) err = 1;
      else void'(q.pop_front());
    end
    if (g >= 0) begin
      if (s_ready) begin
        held = -1;
        prio = 1 - g;
        if (!m_write[g] || m_nposted[g]) q.push_back(g);
      end else held = g;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      compare();
      @(posedge clk);
      if (rst_n) update();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] acc;
    int r;
    m_valid = 2'b11; m_write = 0; m_nposted = 0; m_addr = '0; m_wdat = '0;
    s_ready = 1; s_rvalid = 0; s_wr_complete = 0; s_rdata = 0;
    repeat (3) @(posedge clk);
    #3 chk("rst_s_valid", s_valid, 0);
    chk("rst_m_ready", m_ready, 0);
    m_valid = 0;
    cyc();
    rst_n = 1;
    m_valid = 2'b11; m_addr[0] = 16'h0010; m_addr[1] = 16'h0020;
    for (int i = 0; i < 4; i++) begin
      #1 chk("alternate", m_ready, (i % 2) ? 2'b10 : 2'b01);
      cyc();
    end
    m_valid = 0;
    #1 chk("alt_full", outstanding, 4);
    for (int i = 0; i < 4; i++) begin
      s_rvalid = 1; s_rdata = $urandom;
      #1 chk("resp_order", m_rvalid, (i % 2) ? 2'b10 : 2'b01);
      cyc();
    end
    s_rvalid = 0;
    #1 chk("drained", outstanding, 0);
    m_valid = 2'b01;
    #1 chk("single_ready", m_ready, 2'b01);
    chk("single_addr", s_addr, 16'h0010);
    cyc();
    m_valid = 0;
    #1 chk("single_out1", outstanding, 1);
    s_rvalid = 1; s_rdata = 32'hDEADBEEF;
    #1 chk("single_rvalid", m_rvalid, 2'b01);
    chk("single_rdata", m_rdata[0], 32'hDEADBEEF);
    cyc();
    s_rvalid = 0;
    #1 chk("single_out0", outstanding, 0);
    s_ready = 0; m_valid = 2'b11; m_write = 2'b10; m_nposted = 2'b10;
    m_addr[1] = 16'h0200; m_wdat[1] = 32'hCAFE0001;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_addr", s_addr, 16'h0200);
      chk("stall_wdat", s_wdat, 32'hCAFE0001);
      chk("stall_ready", m_ready, 2'b00);
      cyc();
    end
    s_ready = 1;
    #1 chk("stall_accept", m_ready, 2'b10);
    cyc();
    m_valid = 0; s_ready = 0; m_write = 0; m_nposted = 0; s_wr_complete = 1;
    #1 chk("np_complete", m_wr_complete, 2'b10);
    cyc();
    s_wr_complete = 0; m_valid = 2'b01; s_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("fill_ready", m_ready, 2'b01);
      cyc();
    end
    #1 chk("full_s_valid", s_valid, 0);
    chk("full_ready", m_ready, 2'b00);
    chk("full_out", outstanding, 4);
    s_rvalid = 1;
    #1 chk("full_rvalid", m_rvalid, 2'b01);
    chk("full_pop_s_valid", s_valid, 0);
    cyc();
    s_rvalid = 0;
    #1 chk("fifth_accept", m_ready, 2'b01);
    cyc();
    m_valid = 0; s_rvalid = 1;
    repeat (4) cyc();
    s_rvalid = 0;
    #1 chk("fill_drained", outstanding, 0);
    m_valid = 2'b01; m_write = 2'b01; m_nposted = 0;
    #1 chk("posted_ready", m_ready, 2'b01);
    cyc();
    m_valid = 0; m_write = 0;
    #1 chk("posted_nopush", outstanding, 0);
    chk("err_clear", resp_err, 0);
    s_rvalid = 1;
    cyc();
    s_rvalid = 0;
    repeat (3) cyc();
    #1 chk("err_sticky", resp_err, 1);
    rst_n = 0;
    #1 chk("err_reset", resp_err, 0);
    cyc();
    rst_n = 1; m_valid = 2'b11;
    repeat (2) cyc();
    m_valid = 0;
    #1 chk("midrst_out2", outstanding, 2);
    rst_n = 0;
    #1 chk("midrst_out0", outstanding, 0);
    cyc();
    rst_n = 1; s_rvalid = 1;
    cyc();
    s_rvalid = 0;
    #1 chk("midrst_err", resp_err, 1);
    acc = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!m_valid[i] || acc[i]) begin
          m_valid[i] = ($urandom % 3) != 0;
          m_write[i] = 1'($urandom);
          m_nposted[i] = 1'($urandom);
          m_addr[i] = AW'($urandom);
          m_wdat[i] = $urandom;
        end
      end
      s_ready = ($urandom % 4) != 0;
      r = $urandom % 4;
      s_rvalid = r == 1;
      s_wr_complete = r == 2;
      s_rdata = $urandom;
      rst_n = ($urandom % 400) != 0;
      #1 acc = m_ready;
      cyc();
    end
    rst_n = 1; m_valid = 0; s_rvalid = 0; s_wr_complete = 0;
    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
